// File: rtl/packet_sender_ece496.sv
// packet_sender_ece496: frames {HDR_TAG,sel} + PACKET_LEN FIFO bytes into the UART; in: select_ready/mux_select/empty_fifo_flags/fifo_data/tx_busy, out: fifo_rd_en/tx_data/tx_start/packet_sent/packet_aborted/busy
module packet_sender_ece496 #(
   parameter int PACKET_LEN = 20,
   parameter logic [4:0] HDR_TAG = 5'b10100
) (
   input  logic clock,
   input  logic reset,
   input  logic select_ready,
   input  logic [2:0] mux_select,
   input  logic [7:0] empty_fifo_flags,
   input  logic [63:0] fifo_data,
   output logic [7:0] fifo_rd_en,
   output logic [7:0] tx_data,
   output logic tx_start,
   input  logic tx_busy,
   output logic packet_sent,
   output logic packet_aborted,
   output logic busy
);
   localparam logic [3:0] IDLE = 4'd0, HEADER = 4'd1, HOLD = 4'd2, TXWAIT = 4'd3, READ = 4'd4,
                          LATCH = 4'd5, SEND = 4'd6, DONE = 4'd7, RELEASE = 4'd8;
   logic [3:0] state;
   logic [2:0] sel_q;
   logic [7:0] count;
   logic last, abort;
   assign last = count == 8'(PACKET_LEN);
   assign abort = ~select_ready & (state == HEADER | state == READ | state == LATCH | state == SEND |
                                   (state == TXWAIT & ~tx_busy & ~last));
   assign tx_start = select_ready & ~tx_busy & (state == HEADER | state == SEND);
   assign fifo_rd_en = (state == READ && select_ready && !empty_fifo_flags[sel_q]) ? 8'd1 << sel_q : 8'd0;
   assign busy = state != IDLE;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         sel_q <= '0;
         count <= '0;
         tx_data <= '0;
         packet_sent <= 1'b0;
         packet_aborted <= 1'b0;
      end else begin
         packet_sent <= state == DONE;
         packet_aborted <= abort;
         if (abort) state <= IDLE;
         else case (state)
            IDLE: if (select_ready) begin
               sel_q <= mux_select;
               count <= '0;
               tx_data <= {HDR_TAG, mux_select};
               state <= HEADER;
            end
            HEADER: if (!tx_busy) state <= HOLD;
            HOLD: state <= TXWAIT;
            TXWAIT: if (!tx_busy) state <= last ? DONE : READ;
            READ: if (!empty_fifo_flags[sel_q]) state <= LATCH;
            LATCH: begin
               tx_data <= fifo_data[{sel_q, 3'b000} +: 8];
               state <= SEND;
            end
            SEND: if (!tx_busy) begin
               count <= count + 8'd1;
               state <= HOLD;
            end
            DONE: state <= RELEASE;
            RELEASE: if (!select_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_packet_sender_ece496.sv
// tb_packet_sender_ece496: FIFO/UART models plus scoreboard of expected packet bytes and timing
module tb_packet_sender_ece496;
   localparam int N = 4;
   logic clock = 1'b0, reset = 1'b1, select_ready = 1'b0, tx_busy = 1'b0;
   logic [2:0] mux_select = 3'd0;
   logic [7:0] empty_fifo_flags = 8'hFF;
   logic [63:0] fifo_data = '0;
   logic [7:0] fifo_rd_en, tx_data;
   logic tx_start, packet_sent, packet_aborted, busy;
   int checks = 0, errors = 0;
   int cyc = 0, sent_cnt = 0, abort_cnt = 0, hdr_cyc = 0, sent_cyc = 0, bcnt = 0;
   logic slow = 1'b0, hold_busy = 1'b0, prev_start = 1'b0;
   logic [7:0] rd_seen = '0;
   logic [7:0] fq [8][$];
   logic [7:0] src [8][$];
   logic [7:0] got [$];
   logic [7:0] exp_q [$];

   packet_sender_ece496 #(.PACKET_LEN(N)) dut (
      .clock(clock), .reset(reset), .select_ready(select_ready), .mux_select(mux_select),
      .empty_fifo_flags(empty_fifo_flags), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .packet_sent(packet_sent),
      .packet_aborted(packet_aborted), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clock) begin
      cyc++;
      if (tx_start) begin
         got.push_back(tx_data);
         if (got.size() == 1) hdr_cyc = cyc;
      end
      if (packet_sent) begin
         sent_cnt++;
         sent_cyc = cyc;
      end
      if (packet_aborted) abort_cnt++;
      rd_seen = rd_seen | fifo_rd_en;
      for (int k = 0; k < 8; k++)
         if (fifo_rd_en[k] && fq[k].size() > 0) fifo_data[8*k +: 8] <= fq[k].pop_front();
      for (int k = 0; k < 8; k++) empty_fifo_flags[k] <= fq[k].size() == 0;
      if (bcnt > 0) bcnt--;
      if (tx_start && slow) bcnt = 11;
      tx_busy <= hold_busy || (bcnt > 0 && bcnt <= 10);
   end

   always @(negedge clock)
      if (!reset) begin
         check("rd_onehot", int'($onehot0(fifo_rd_en)), 1);
         check("rd_empty", int'(fifo_rd_en & empty_fifo_flags), 0);
         check("start_while_busy", int'(tx_start & tx_busy), 0);
         check("start_b2b", int'(tx_start & prev_start), 0);
         prev_start = tx_start;
      end

   task automatic push_both(int s, logic [7:0] b);
      fq[s].push_back(b);
      src[s].push_back(b);
   endtask

   task automatic start_pkt(int s);
      got.delete();
      exp_q.delete();
      rd_seen = '0;
      exp_q.push_back({5'b10100, 3'(s)});
      for (int i = 0; i < N; i++) exp_q.push_back(src[s].pop_front());
      mux_select = 3'(s);
      select_ready = 1'b1;
   endtask

   task automatic wait_sent(string tag);
      int i;
      i = 0;
      while (!packet_sent && i < 3000) begin
         @(negedge clock);
         i++;
      end
      check(tag, int'(packet_sent), 1);
   endtask

   task automatic cmp_bytes(string tag);
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, int'(got[i]), int'(exp_q[i]));
   endtask

   initial begin
      int s, s0, a0, psc;
      logic [7:0] b [4];
      @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_start", int'(tx_start), 0);
      check("rst_rd", int'(fifo_rd_en), 0);
      check("rst_txdata", int'(tx_data), 0);
      check("rst_sent", int'(packet_sent), 0);
      check("rst_abort", int'(packet_aborted), 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      push_both(3, 8'h11);
      push_both(3, 8'h22);
      push_both(3, 8'h33);
      push_both(3, 8'h44);
      repeat (2) @(negedge clock);
      s0 = sent_cnt;
      start_pkt(3);
      wait_sent("s2_sent");
      select_ready = 1'b0;
      mux_select = 3'bz;
      @(negedge clock);
      cmp_bytes("s2_byte");
      check("s2_latency", sent_cyc - hdr_cyc, 5 * N + 4);
      check("s2_rd_only3", int'(rd_seen), 8'h08);
      repeat (4) @(negedge clock);
      check("s2_one_pulse", sent_cnt - s0, 1);
      slow = 1'b1;
      s = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) push_both(s, 8'($urandom));
      repeat (2) @(negedge clock);
      s0 = sent_cnt;
      start_pkt(s);
      wait_sent("s3_sent");
      select_ready = 1'b0;
      mux_select = 3'bz;
      @(negedge clock);
      cmp_bytes("s3_byte");
      repeat (4) @(negedge clock);
      check("s3_one_pulse", sent_cnt - s0, 1);
      slow = 1'b0;
      repeat (12) @(negedge clock);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) src[5].push_back(b[i]);
      fq[5].push_back(b[0]);
      fq[5].push_back(b[1]);
      repeat (2) @(negedge clock);
      start_pkt(5);
      for (int i = 0; i < 500 && fq[5].size() != 0; i++) @(negedge clock);
      check("s4_drained", fq[5].size(), 0);
      repeat (30) @(negedge clock);
      check("s4_stall_rd", int'(fifo_rd_en), 0);
      check("s4_stall_busy", int'(busy), 1);
      check("s4_stall_got", got.size(), 3);
      fq[5].push_back(b[2]);
      fq[5].push_back(b[3]);
      wait_sent("s4_sent");
      select_ready = 1'b0;
      mux_select = 3'bz;
      @(negedge clock);
      cmp_bytes("s4_byte");
      s = $urandom_range(0, 6);
      push_both(s, 8'($urandom));
      for (int i = 1; i < N; i++) src[s].push_back(8'h00);
      repeat (2) @(negedge clock);
      start_pkt(s);
      for (int i = 0; i < 500 && fq[s].size() != 0; i++) @(negedge clock);
      repeat (6) @(negedge clock);
      s0 = sent_cnt;
      a0 = abort_cnt;
      select_ready = 1'b0;
      mux_select = 3'bz;
      repeat (5) @(negedge clock);
      check("s5_abort_pulse", abort_cnt - a0, 1);
      check("s5_no_sent", sent_cnt - s0, 0);
      check("s5_idle", int'(busy), 0);
      check("s5_got", got.size(), 2);
      src[s] = fq[s];
      for (int i = 0; i < 2 * N; i++) push_both(7, 8'($urandom));
      repeat (2) @(negedge clock);
      start_pkt(7);
      wait_sent("s5_sent7");
      select_ready = 1'b0;
      @(negedge clock);
      cmp_bytes("s5_byte7");
      psc = sent_cyc;
      start_pkt(7);
      wait_sent("s6_sent");
      select_ready = 1'b0;
      mux_select = 3'bz;
      @(negedge clock);
      cmp_bytes("s6_byte");
      check("s6_restart", hdr_cyc - psc, 2);
      s = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) push_both(s, 8'($urandom));
      repeat (2) @(negedge clock);
      start_pkt(s);
      for (int i = 0; i < 500 && fifo_rd_en == 8'd0; i++) @(negedge clock);
      hold_busy = 1'b1;
      repeat (2) @(negedge clock);
      check("s1_pre_busy", int'(busy), 1);
      #2 reset = 1'b1;
      #1;
      check("s1_busy", int'(busy), 0);
      check("s1_start", int'(tx_start), 0);
      check("s1_rd", int'(fifo_rd_en), 0);
      check("s1_txdata", int'(tx_data), 0);
      check("s1_sent", int'(packet_sent), 0);
      check("s1_abort", int'(packet_aborted), 0);
      hold_busy = 1'b0;
      select_ready = 1'b0;
      mux_select = 3'bz;
      s0 = sent_cnt;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      check("s1_idle", int'(busy), 0);
      check("s1_no_sent", sent_cnt - s0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
